// File: rtl/dsi_line_fifo_sched.sv
// Line-burst scheduler between the pixel source and the 256x32b DSI line FIFO.
// Writes are pass-through; reads drain exactly LINE_WORDS words per line_req, padding with FILL_WORD on underrun.
module dsi_line_fifo_sched #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter int                LVL_W       = 9,
    parameter int                LINE_WORDS  = 240,
    parameter int                START_LEVEL = 64,
    parameter logic [DATA_W-1:0] FILL_WORD   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              line_req,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [LVL_W-1:0]  level,
    output logic              underrun,
    output logic              req_drop,
    input  logic              err_clr,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_wr_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty
);

    // state  | meaning
    // IDLE   | waiting for line_req
    // FILL   | line accepted, waiting for level >= START_LEVEL
    // STREAM | one read slot per cycle, LINE_WORDS slots
    // TAIL   | last word on the output, no slot
    typedef enum logic [1:0] {IDLE, FILL, STREAM, TAIL} state_t;

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] START_L = LVL_W'(START_LEVEL);
    localparam logic [15:0]      LAST_W  = 16'(LINE_WORDS - 1);

    state_t      state, state_nxt;
    logic [15:0] word_cnt, word_cnt_nxt;
    logic        slot, slot_last;
    logic        valid_q, rd_q, last_q;

    assign src_ready    = ~fifo_wr_full;
    assign fifo_wr_en   = src_valid & src_ready;
    assign fifo_wr_data = src_data;

    assign slot       = (state == STREAM);
    assign slot_last  = slot && (word_cnt == LAST_W);
    assign fifo_rd_en = slot & ~fifo_rd_empty;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        case (state)
            IDLE:   if (line_req) state_nxt = FILL;
            FILL:   if (level >= START_L) begin
                        state_nxt    = STREAM;
                        word_cnt_nxt = '0;
                    end
            STREAM: begin
                        word_cnt_nxt = word_cnt + 16'd1;
                        if (slot_last) state_nxt = TAIL;
                    end
            TAIL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    // Simultaneous write and read leave the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (fifo_wr_en && !fifo_rd_en && level != DEPTH_L) begin
            level <= level + LVL_W'(1);
        end else if (!fifo_wr_en && fifo_rd_en && level != '0) begin
            level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
            req_drop <= 1'b0;
        end else begin
            if (slot && fifo_rd_empty) underrun <= 1'b1;
            else if (err_clr)          underrun <= 1'b0;
            if (line_req && state != IDLE) req_drop <= 1'b1;
            else if (err_clr)              req_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= slot;
            rd_q    <= fifo_rd_en;
            last_q  <= slot_last;
        end
    end

    // FIFO read data has no output register, so it lines up with the delayed slot strobe.
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = valid_q ? (rd_q ? fifo_rd_data : FILL_WORD) : '0;

endmodule

// File: tb/tb_dsi_line_fifo_sched.sv
// Directed bench: two scheduler instances (64-word and 240-word lines), each on its own behavioural FIFO.
module tb_dsi_line_fifo_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        src_valid [2];
    logic        src_ready [2];
    logic        line_req  [2];
    logic        out_valid [2];
    logic        out_last  [2];
    logic        busy      [2];
    logic        underrun  [2];
    logic        req_drop  [2];
    logic        err_clr   [2];
    logic        wr_en     [2];
    logic        rd_en     [2];
    logic        wr_full   [2];
    logic        rd_empty  [2];
    logic [31:0] src_data  [2];
    logic [31:0] out_data  [2];
    logic [31:0] wr_data   [2];
    logic [31:0] rd_data   [2];
    logic [8:0]  level     [2];

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_env
        logic [31:0] mem [256];
        logic [7:0]  wp, rp;
        logic [8:0]  cnt;
        logic [31:0] rdq;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp  <= 8'd0;
                rp  <= 8'd0;
                cnt <= 9'd0;
                rdq <= 32'd0;
            end else begin
                if (wr_en[g]) begin
                    mem[wp] <= wr_data[g];
                    wp      <= wp + 8'd1;
                end
                if (rd_en[g]) begin
                    rdq <= mem[rp];
                    rp  <= rp + 8'd1;
                end
                cnt <= cnt + {8'd0, wr_en[g]} - {8'd0, rd_en[g]};
            end
        end

        assign wr_full[g]  = (cnt == 9'd256);
        assign rd_empty[g] = (cnt == 9'd0);
        assign rd_data[g]  = rdq;

        dsi_line_fifo_sched #(
            .LINE_WORDS ((g == 0) ? 64 : 240),
            .FILL_WORD  ((g == 0) ? 32'h0000_0000 : 32'hDEAD_BEEF)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .src_valid     (src_valid[g]),
            .src_data      (src_data[g]),
            .src_ready     (src_ready[g]),
            .line_req      (line_req[g]),
            .out_valid     (out_valid[g]),
            .out_data      (out_data[g]),
            .out_last      (out_last[g]),
            .busy          (busy[g]),
            .level         (level[g]),
            .underrun      (underrun[g]),
            .req_drop      (req_drop[g]),
            .err_clr       (err_clr[g]),
            .fifo_wr_en    (wr_en[g]),
            .fifo_wr_data  (wr_data[g]),
            .fifo_wr_full  (wr_full[g]),
            .fifo_rd_en    (rd_en[g]),
            .fifo_rd_data  (rd_data[g]),
            .fifo_rd_empty (rd_empty[g])
        );
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Writes n words base..base+n-1, one per cycle; returns with the source idle.
    task automatic prefill(input int k, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            src_valid[k] = 1'b1;
            src_data[k]  = 32'(base + i);
        end
        @(negedge clk);
        src_valid[k] = 1'b0;
    endtask

    // Request in cycle 0; returns at the start of cycle 1.
    task automatic req_pulse(input int k);
        @(negedge clk);
        line_req[k] = 1'b1;
        @(negedge clk);
        line_req[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({out_valid[k], out_last[k], busy[k], underrun[k], req_drop[k], rd_en[k], level[k], out_data[k]} !== 47'd0)
                $display("FAIL reset_outputs%0d valid=%0b last=%0b busy=%0b und=%0b drop=%0b rd=%0b level=%0d data=%0h exp all zero",
                         k, out_valid[k], out_last[k], busy[k], underrun[k], req_drop[k], rd_en[k], level[k], out_data[k]);
            else passed++;
            total++;
            if (src_ready[k] !== 1'b1) $display("FAIL reset_src_ready%0d got=%0b exp=1", k, src_ready[k]);
            else passed++;
        end
    endtask

    task automatic test_basic_line();
        do_reset();
        prefill(0, 100, 0);
        total++;
        if (level[0] !== 9'd100) $display("FAIL t1_prefill_level got=%0d exp=100", level[0]);
        else passed++;
        req_pulse(0);
        #1;
        total++;
        if (busy[0] !== 1'b1 || rd_en[0] !== 1'b0 || out_valid[0] !== 1'b0)
            $display("FAIL t1_cycle1 busy=%0b rd=%0b valid=%0b exp 1 0 0", busy[0], rd_en[0], out_valid[0]);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (rd_en[0] !== 1'b1 || out_valid[0] !== 1'b0)
            $display("FAIL t1_cycle2 rd=%0b valid=%0b exp 1 0", rd_en[0], out_valid[0]);
        else passed++;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk); #1;
            total++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 32'(j) || out_last[0] !== (j == 63) || busy[0] !== 1'b1)
                $display("FAIL t1_word%0d valid=%0b data=%0h last=%0b busy=%0b exp 1 %0h %0b 1",
                         j, out_valid[0], out_data[0], out_last[0], busy[0], j, j == 63);
            else passed++;
        end
        @(negedge clk); #1;
        total++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || level[0] !== 9'd36 || underrun[0] !== 1'b0)
            $display("FAIL t1_end busy=%0b valid=%0b level=%0d und=%0b exp 0 0 36 0", busy[0], out_valid[0], level[0], underrun[0]);
        else passed++;
    endtask

    task automatic test_fill_wait();
        do_reset();
        req_pulse(0);
        #1;
        total++;
        if (busy[0] !== 1'b1) $display("FAIL t2_busy got=%0b exp=1", busy[0]);
        else passed++;
        repeat (4) begin
            @(negedge clk); #1;
            total++;
            if (rd_en[0] !== 1'b0) $display("FAIL t2_stall_rd got=%0b exp=0", rd_en[0]);
            else passed++;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            src_valid[0] = 1'b1;
            src_data[0]  = 32'(i);
            #1;
            total++;
            if (rd_en[0] !== 1'b0 || level[0] !== 9'(i))
                $display("FAIL t2_fill%0d rd=%0b level=%0d exp 0 %0d", i, rd_en[0], level[0], i);
            else passed++;
        end
        @(negedge clk);
        src_valid[0] = 1'b0;
        #1;
        total++;
        if (rd_en[0] !== 1'b0 || level[0] !== 9'd64)
            $display("FAIL t2_at_threshold rd=%0b level=%0d exp 0 64", rd_en[0], level[0]);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (rd_en[0] !== 1'b1) $display("FAIL t2_stream_start rd=%0b exp=1", rd_en[0]);
        else passed++;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk); #1;
            total++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 32'(j) || out_last[0] !== (j == 63))
                $display("FAIL t2_word%0d valid=%0b data=%0h last=%0b exp 1 %0h %0b",
                         j, out_valid[0], out_data[0], out_last[0], j, j == 63);
            else passed++;
        end
        @(negedge clk); #1;
        total++;
        if (busy[0] !== 1'b0 || level[0] !== 9'd0 || underrun[0] !== 1'b0)
            $display("FAIL t2_end busy=%0b level=%0d und=%0b exp 0 0 0", busy[0], level[0], underrun[0]);
        else passed++;
    endtask

    task automatic test_underrun();
        int viol;
        logic [31:0] exp_d;
        viol = 0;
        do_reset();
        prefill(1, 64, 32'h100);
        req_pulse(1);
        #1;
        for (int c = 2; c <= 242; c++) begin
            @(negedge clk); #1;
            if (rd_en[1] === 1'b1 && rd_empty[1] === 1'b1) viol++;
            if (c >= 3) begin
                exp_d = (c - 3 < 64) ? 32'(32'h100 + c - 3) : 32'hDEAD_BEEF;
                total++;
                if (out_valid[1] !== 1'b1 || out_data[1] !== exp_d || out_last[1] !== (c == 242))
                    $display("FAIL t3_word%0d valid=%0b data=%0h last=%0b exp 1 %0h %0b",
                             c - 3, out_valid[1], out_data[1], out_last[1], exp_d, c == 242);
                else passed++;
            end
        end
        total++;
        if (viol !== 0) $display("FAIL t3_read_on_empty got=%0d cycles exp=0", viol);
        else passed++;
        total++;
        if (underrun[1] !== 1'b1 || level[1] !== 9'd0)
            $display("FAIL t3_flags und=%0b level=%0d exp 1 0", underrun[1], level[1]);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || underrun[1] !== 1'b1)
            $display("FAIL t3_end busy=%0b valid=%0b und=%0b exp 0 0 1", busy[1], out_valid[1], underrun[1]);
        else passed++;
        err_clr[1] = 1'b1;
        @(negedge clk);
        err_clr[1] = 1'b0;
        #1;
        total++;
        if (underrun[1] !== 1'b0 || req_drop[1] !== 1'b0)
            $display("FAIL t3_err_clr und=%0b drop=%0b exp 0 0", underrun[1], req_drop[1]);
        else passed++;
    endtask

    task automatic test_full_overlap();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            src_valid[0] = 1'b1;
            src_data[0]  = 32'(i);
            #1;
            if (i >= 256) begin
                total++;
                if (src_ready[0] !== 1'b0 || wr_en[0] !== 1'b0 || level[0] !== 9'd256)
                    $display("FAIL t4_full%0d ready=%0b wr=%0b level=%0d exp 0 0 256", i, src_ready[0], wr_en[0], level[0]);
                else passed++;
            end
        end
        req_pulse(0);
        #1;
        @(negedge clk); #1;
        total++;
        if (rd_en[0] !== 1'b1 || wr_en[0] !== 1'b0 || level[0] !== 9'd256)
            $display("FAIL t4_first_read rd=%0b wr=%0b level=%0d exp 1 0 256", rd_en[0], wr_en[0], level[0]);
        else passed++;
        for (int c = 3; c <= 66; c++) begin
            @(negedge clk); #1;
            total++;
            if (level[0] !== 9'd255 || out_valid[0] !== 1'b1 || out_data[0] !== 32'(c - 3))
                $display("FAIL t4_overlap%0d level=%0d valid=%0b data=%0h exp 255 1 %0h",
                         c, level[0], out_valid[0], out_data[0], c - 3);
            else passed++;
        end
        @(negedge clk);
        src_valid[0] = 1'b0;
        #1;
        total++;
        if (level[0] !== 9'd256 || busy[0] !== 1'b0)
            $display("FAIL t4_end level=%0d busy=%0b exp 256 0", level[0], busy[0]);
        else passed++;
    endtask

    task automatic test_req_drop();
        do_reset();
        prefill(0, 100, 0);
        req_pulse(0);
        #1;
        for (int c = 2; c <= 69; c++) begin
            @(negedge clk);
            line_req[0] = (c == 10) || (c == 20);
            err_clr[0]  = (c == 20);
            #1;
            if (c >= 3 && c <= 66) begin
                total++;
                if (out_valid[0] !== 1'b1 || out_data[0] !== 32'(c - 3))
                    $display("FAIL t5_word%0d valid=%0b data=%0h exp 1 %0h", c - 3, out_valid[0], out_data[0], c - 3);
                else passed++;
            end
            if (c == 10 || c == 11 || c == 21) begin
                total++;
                if (req_drop[0] !== (c != 10))
                    $display("FAIL t5_drop_c%0d got=%0b exp=%0b", c, req_drop[0], c != 10);
                else passed++;
            end
            if (c >= 67) begin
                total++;
                if (busy[0] !== 1'b0 || level[0] !== 9'd36)
                    $display("FAIL t5_no_second_line_c%0d busy=%0b level=%0d exp 0 36", c, busy[0], level[0]);
                else passed++;
            end
        end
        @(negedge clk);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        #1;
        total++;
        if (req_drop[0] !== 1'b0 || underrun[0] !== 1'b0)
            $display("FAIL t5_err_clr drop=%0b und=%0b exp 0 0", req_drop[0], underrun[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_d;
        do_reset();
        prefill(0, 200, 0);
        req_pulse(0);
        #1;
        for (int c = 2; c <= 134; c++) begin
            @(negedge clk);
            line_req[0] = (c == 67);
            #1;
            exp_v = (c >= 3 && c <= 66) || (c >= 70 && c <= 133);
            exp_d = !exp_v ? 32'd0 : (c <= 66) ? 32'(c - 3) : 32'(c - 70 + 64);
            total++;
            if (out_valid[0] !== exp_v || out_data[0] !== exp_d || out_last[0] !== (c == 66 || c == 133))
                $display("FAIL t6_c%0d valid=%0b data=%0h last=%0b exp %0b %0h %0b",
                         c, out_valid[0], out_data[0], out_last[0], exp_v, exp_d, c == 66 || c == 133);
            else passed++;
        end
        total++;
        if (busy[0] !== 1'b0 || req_drop[0] !== 1'b0 || level[0] !== 9'd72)
            $display("FAIL t6_end busy=%0b drop=%0b level=%0d exp 0 0 72", busy[0], req_drop[0], level[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        prefill(0, 100, 0);
        req_pulse(0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || level[0] !== 9'd0 || rd_en[0] !== 1'b0)
            $display("FAIL t7_async_reset valid=%0b busy=%0b level=%0d rd=%0b exp 0 0 0 0",
                     out_valid[0], busy[0], level[0], rd_en[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        prefill(0, 64, 32'h500);
        req_pulse(0);
        #1;
        @(negedge clk); #1;
        total++;
        if (rd_en[0] !== 1'b1 || out_valid[0] !== 1'b0)
            $display("FAIL t7_restart rd=%0b valid=%0b exp 1 0", rd_en[0], out_valid[0]);
        else passed++;
        for (int j = 0; j < 64; j++) begin
            @(negedge clk); #1;
            total++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 32'(32'h500 + j) || out_last[0] !== (j == 63))
                $display("FAIL t7_word%0d valid=%0b data=%0h last=%0b exp 1 %0h %0b",
                         j, out_valid[0], out_data[0], out_last[0], 32'h500 + j, j == 63);
            else passed++;
        end
        @(negedge clk); #1;
        total++;
        if (busy[0] !== 1'b0 || underrun[0] !== 1'b0 || level[0] !== 9'd0)
            $display("FAIL t7_end busy=%0b und=%0b level=%0d exp 0 0 0", busy[0], underrun[0], level[0]);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            src_valid[k] = 1'b0;
            src_data[k]  = 32'd0;
            line_req[k]  = 1'b0;
            err_clr[k]   = 1'b0;
        end
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic_line();
        test_fill_wait();
        test_underrun();
        test_full_overlap();
        test_req_drop();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dsi_line_fifo_sched.md
# dsi_line_fifo_sched

Read/write scheduler for the 256x32b synchronous line FIFO in the MIPI DSI video path. It accepts pixel words from the colour-bar/pixel source with a valid/ready handshake and writes them into the FIFO. On each `line_req` from the DSI timing generator, it waits for a fill threshold and then drains exactly `LINE_WORDS` words to the DSI packetizer as an unbroken burst. If the FIFO runs dry mid-line, it substitutes fill words to keep line length exact and flags the underrun.

## Interface
Parameters:
- `DATA_W`, 32, word width; matches FIFO data width.
- `DEPTH`, 256, FIFO depth in words.
- `LVL_W`, 9, occupancy width, equal to clog2(`DEPTH`)+1.
- `LINE_WORDS`, 240, words per line; legal range 1..65535.
- `START_LEVEL`, 64, minimum occupancy before a line burst starts; legal range 1..`DEPTH`.
- `FILL_WORD`, 32'h0000_0000, data emitted in place of a missing word on underrun.

Ports:
- `clk`  in  1  single clock for the block and the FIFO.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  1  source word valid.
- `src_data`  in  `DATA_W`  source word.
- `src_ready`  out  1  block can accept a word; transfer happens when `src_valid` and `src_ready` are both high.
- `line_req`  in  1  single-cycle pulse requesting one line burst.
- `out_valid`  out  1  `out_data` is valid this cycle; the consumer has no backpressure.
- `out_data`  out  `DATA_W`  line word.
- `out_last`  out  1  final word of the line.
- `busy`  out  1  a line is in progress.
- `level`  out  `LVL_W`  current FIFO occupancy.
- `underrun`  out  1  sticky: the FIFO was empty during a burst.
- `req_drop`  out  1  sticky: a `line_req` arrived while not IDLE.
- `err_clr`  in  1  synchronous clear of both sticky flags.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  `DATA_W`  FIFO write data.
- `fifo_wr_full`  in  1  FIFO full flag.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_rd_data`  in  `DATA_W`  FIFO read data; valid one cycle after `fifo_rd_en` (no output register).
- `fifo_rd_empty`  in  1  FIFO empty flag.

## Operation
- Write side is combinational:
  - `src_ready` = ~`fifo_wr_full`.
  - `fifo_wr_en` = `src_valid` & `src_ready`.
  - `fifo_wr_data` = `src_data`.
  - Writes are independent of the state machine.
- `level` is a registered counter:
  - +1 on `fifo_wr_en` only; −1 on `fifo_rd_en` only; unchanged when both or neither are active.
  - Saturates at 0 and at `DEPTH`; never wraps.
- State machine:
  - IDLE: on `line_req`, go to FILL; `busy` goes high on the next cycle.
  - FILL: when `level` ≥ `START_LEVEL`, load the word counter with 0 and go to STREAM.
  - STREAM: one word slot per cycle, `LINE_WORDS` slots in total. After the slot with counter = `LINE_WORDS`−1, go to TAIL.
  - TAIL: one cycle in which the last word is presented; then return to IDLE.
- Per STREAM slot:
  - `fifo_rd_en` = ~`fifo_rd_empty`. A read is never issued on empty.
  - If empty: no read occurs, `underrun` sets, and the corresponding output word is `FILL_WORD`.
- Output stage:
  - `out_valid` is the slot strobe delayed one cycle.
  - `out_data` = `fifo_rd_data` if that slot read, else `FILL_WORD`.
  - `out_last` is high on the word of slot `LINE_WORDS`−1.
- `line_req` while not IDLE is ignored and sets `req_drop`.
- `err_clr` clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- Reset mid-burst: immediate return to IDLE. All outputs go to reset values and `level` goes to 0. The FIFO shares `rst_n` (inverted), so its contents are discarded.

## Timing
- Reset values: `src_ready` follows `fifo_wr_full`; all other outputs are 0; state is IDLE.
- Minimum latency, with `line_req` at cycle 0 and `level` ≥ `START_LEVEL`:
  - FILL in cycle 1.
  - First `fifo_rd_en` in cycle 2.
  - First `out_valid` in cycle 3.
  - `out_last` in cycle `LINE_WORDS`+2.
  - IDLE again in cycle `LINE_WORDS`+3; a new `line_req` is accepted there.
- `out_valid` is high for exactly `LINE_WORDS` consecutive cycles per line, with no gaps.
- `busy` is high from the cycle after `line_req` through the `out_last` cycle inclusive.
- FILL waits indefinitely; there is no timeout.

## Test plan
- Prefill 100 words (data 0..99), then pulse `line_req` with `LINE_WORDS`=64 → first `out_valid` 3 cycles after the request; 64 consecutive words 0..63; `out_last` on word 63; `level` ends at 36; `underrun`=0.
- Source stalled, `line_req` pulsed, then 64 words written → stays in FILL until `level`=64; STREAM starts the cycle after; output is 0..63 in order.
- Prefill exactly 64 words with `LINE_WORDS`=240 and source idle → 64 real words followed by 176 `FILL_WORD` words; `underrun`=1; no `fifo_rd_en` while empty; `level`=0.
- Write 256 words with the source held valid → `src_ready`=0 at full; `level`=256; no further writes; then run a line with simultaneous write/read → `level` stays constant during the overlap.
- Second `line_req` mid-burst → `req_drop`=1 and burst unaffected; `err_clr` → both flags back to 0.
- `rst_n` low for 1 cycle mid-STREAM → `out_valid`, `busy` and `level` go to 0 immediately; a following `line_req` runs a clean line from FILL.
